// File: rtl/weight_row_streamer.sv
// Reads consecutive rows from the weight bank and streams each row's three packed
// signed weights, sign-extended, to the MAC datapath over a valid/ready handshake.
module weight_row_streamer #(
   parameter int Amba_Addr_Depth = 12,
   parameter int WeightPrecision = 5,
   parameter int WeightRowWidth  = 15,
   parameter int OutWidth        = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   input  logic [Amba_Addr_Depth-1:0]  base_addr,
   input  logic [Amba_Addr_Depth:0]    row_count,
   output logic [1:0]                  bank_control,
   output logic [Amba_Addr_Depth:0]    bank_address,
   input  logic [WeightRowWidth-1:0]   bank_data,
   output logic [OutWidth-1:0]         w_data,
   output logic                        w_valid,
   input  logic                        w_ready,
   output logic                        w_last,
   output logic                        busy,
   output logic                        done
);

   localparam int AW = Amba_Addr_Depth + 1;
   localparam logic [1:0] CTRL_READ = 2'b10;
   localparam logic [1:0] CTRL_NONE = 2'b00;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT, S_DONE} state_t;

   state_t                       state_reg;
   logic [Amba_Addr_Depth-1:0]   addr_reg;
   logic [AW-1:0]                count_reg;
   logic [AW-1:0]                row_idx_reg;
   logic [WeightRowWidth-1:0]    row_reg;
   logic [1:0]                   lane_reg;
   logic [OutWidth-1:0]          row_lane [3];
   logic [OutWidth-1:0]          bank_lane0;
   logic [Amba_Addr_Depth-1:0]   addr_next;
   logic                         last_row;

   // Sign-extended view of each packed lane of the captured row.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_lane
         assign row_lane[gi] = OutWidth'($signed(row_reg[gi*WeightPrecision +: WeightPrecision]));
      end
   endgenerate

   assign bank_lane0 = OutWidth'($signed(bank_data[WeightPrecision-1:0]));
   assign addr_next  = addr_reg + Amba_Addr_Depth'(1);
   assign last_row   = (row_idx_reg == count_reg - AW'(1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg    <= S_IDLE;
         addr_reg     <= '0;
         count_reg    <= '0;
         row_idx_reg  <= '0;
         row_reg      <= '0;
         lane_reg     <= '0;
         bank_control <= CTRL_NONE;
         bank_address <= '0;
         w_data       <= '0;
         w_valid      <= 1'b0;
         w_last       <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (row_count != '0) begin
                     addr_reg     <= base_addr;
                     count_reg    <= row_count;
                     row_idx_reg  <= '0;
                     bank_control <= CTRL_READ;
                     bank_address <= {1'b0, base_addr};
                     state_reg    <= S_ISSUE;
                  end else begin
                     done      <= 1'b1;
                     state_reg <= S_DONE;
                  end
               end
            end
            S_ISSUE: begin
               bank_control <= CTRL_NONE;
               state_reg    <= S_WAIT;
            end
            S_WAIT: begin
               row_reg   <= bank_data;
               lane_reg  <= 2'd0;
               w_data    <= bank_lane0;
               w_valid   <= 1'b1;
               w_last    <= 1'b0;
               state_reg <= S_EMIT;
            end
            S_EMIT: begin
               // Outputs only advance on a handshake, so they hold during stalls.
               if (w_ready) begin
                  if (lane_reg != 2'd2) begin
                     lane_reg <= lane_reg + 2'd1;
                     w_data   <= (lane_reg == 2'd0) ? row_lane[1] : row_lane[2];
                     w_last   <= (lane_reg == 2'd1) && last_row;
                  end else begin
                     w_valid <= 1'b0;
                     w_last  <= 1'b0;
                     if (last_row) begin
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                     end else begin
                        row_idx_reg  <= row_idx_reg + AW'(1);
                        addr_reg     <= addr_next;
                        bank_control <= CTRL_READ;
                        bank_address <= {1'b0, addr_next};
                        state_reg    <= S_ISSUE;
                     end
                  end
               end
            end
            S_DONE: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_row_streamer.sv
// Bench for weight_row_streamer: precision-8 and precision-5 instances share stimulus,
// a registered-read bank model, and a queue-based reference of the expected stream.
module tb_weight_row_streamer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [11:0] base_addr = '0;
   logic [12:0] row_count = '0;
   logic        w_ready = 1'b0;
   logic        use5 = 1'b0;

   logic [1:0]  ctrl8, ctrl5;
   logic [12:0] addr8, addr5;
   logic [23:0] data8 = '0;
   logic [14:0] data5 = '0;
   logic [15:0] wd8, wd5;
   logic        wv8, wv5, wl8, wl5, busy8, busy5, done8, done5;

   logic [23:0] mem [4096];

   int total  = 0;
   int passed = 0;
   int first_valid, last_hs, done_cyc, nreads;
   logic [15:0] exp_w [$];
   logic [11:0] exp_a [$];
   logic [15:0] got_w [$];

   always #5 clock = ~clock;

   weight_row_streamer #(.Amba_Addr_Depth(12), .WeightPrecision(8), .WeightRowWidth(24), .OutWidth(16)) dut8 (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .row_count(row_count),
      .bank_control(ctrl8), .bank_address(addr8), .bank_data(data8),
      .w_data(wd8), .w_valid(wv8), .w_ready(w_ready), .w_last(wl8), .busy(busy8), .done(done8));

   weight_row_streamer dut5 (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .row_count(row_count),
      .bank_control(ctrl5), .bank_address(addr5), .bank_data(data5),
      .w_data(wd5), .w_valid(wv5), .w_ready(w_ready), .w_last(wl5), .busy(busy5), .done(done5));

   // Bank: READ in cycle t, data visible in cycle t+1.
   always @(posedge clock) begin
      if (ctrl8 == 2'b10) data8 <= mem[addr8[11:0]];
      if (ctrl5 == 2'b10) data5 <= mem[addr5[11:0]][14:0];
   end

   wire [1:0]  s_ctrl  = use5 ? ctrl5 : ctrl8;
   wire [12:0] s_addr  = use5 ? addr5 : addr8;
   wire [15:0] s_data  = use5 ? wd5   : wd8;
   wire        s_valid = use5 ? wv5   : wv8;
   wire        s_last  = use5 ? wl5   : wl8;
   wire        s_busy  = use5 ? busy5 : busy8;
   wire        s_done  = use5 ? done5 : done8;

   function automatic logic [15:0] sext(input logic [23:0] row, input int lane, input int wp);
      int v;
      v = (int'(row) >> (lane * wp)) & ((1 << wp) - 1);
      if (v >= (1 << (wp - 1))) v = v - (1 << wp);
      return 16'(v);
   endfunction

   function automatic logic ready_at(input int mode, input int k);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (k % 2) == 1;
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic run_stream(input logic [11:0] base, input logic [12:0] cnt, input int mode,
                             input bit sel5, input bit poke_busy, input bit immediate, input string tag);
      int wp;
      logic [11:0] a;
      logic [15:0] want;
      logic prev_valid, prev_ready, prev_last;
      logic [15:0] prev_data;
      wp = sel5 ? 5 : 8;
      exp_w.delete(); exp_a.delete(); got_w.delete();
      for (int r = 0; r < int'(cnt); r++) begin
         a = 12'((int'(base) + r) % 4096);
         exp_a.push_back(a);
         for (int l = 0; l < 3; l++) exp_w.push_back(sext(mem[a], l, wp));
      end
      first_valid = -1; last_hs = -1; done_cyc = -1; nreads = 0;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0; prev_data = '0;
      if (!immediate) @(negedge clock);
      use5 = sel5; base_addr = base; row_count = cnt; start = 1'b1; w_ready = 1'b0;
      for (int k = 1; k <= 600; k++) begin
         @(negedge clock);
         if (k == 1) start = 1'b0;
         if (poke_busy && k == 2) begin start = 1'b1; base_addr = base + 12'd7; row_count = 13'd1; end
         if (poke_busy && k == 3) start = 1'b0;
         w_ready = ready_at(mode, k);
         total++; if (s_busy !== 1'b1) $display("FAIL %s busy cycle %0d: got %b want 1", tag, k, s_busy); else passed++;
         total++; if (s_ctrl !== 2'b00 && s_ctrl !== 2'b10) $display("FAIL %s ctrl cycle %0d: got %b want 00/10", tag, k, s_ctrl); else passed++;
         if (s_ctrl == 2'b10) begin
            nreads++;
            total++;
            if (exp_a.size() == 0) $display("FAIL %s extra read cycle %0d: got addr %0d want none", tag, k, s_addr);
            else begin
               a = exp_a.pop_front();
               if (s_addr !== {1'b0, a}) $display("FAIL %s read addr: got %0d want %0d", tag, s_addr, a); else passed++;
            end
         end
         if (prev_valid && !prev_ready) begin
            total++;
            if ({s_valid, s_last, s_data} !== {1'b1, prev_last, prev_data})
               $display("FAIL %s stall hold cycle %0d: got v%b l%b %h want v1 l%b %h", tag, k, s_valid, s_last, s_data, prev_last, prev_data);
            else passed++;
         end
         if (s_valid) begin
            if (first_valid < 0) first_valid = k;
            if (w_ready) begin
               total++;
               got_w.push_back(s_data);
               last_hs = k;
               if (exp_w.size() == 0) $display("FAIL %s extra weight cycle %0d: got %h want none", tag, k, s_data);
               else begin
                  want = exp_w.pop_front();
                  if ({s_data, s_last} !== {want, exp_w.size() == 0})
                     $display("FAIL %s weight cycle %0d: got %h last %b want %h last %b", tag, k, s_data, s_last, want, exp_w.size() == 0);
                  else passed++;
               end
            end
         end
         prev_valid = s_valid; prev_ready = w_ready; prev_last = s_last; prev_data = s_data;
         if (s_done) begin done_cyc = k; break; end
      end
      total++; if (done_cyc < 0) $display("FAIL %s done timeout: got none want pulse", tag); else passed++;
      total++; if (exp_w.size() != 0) $display("FAIL %s weights missing: got %0d left want 0", tag, exp_w.size()); else passed++;
      total++; if (exp_a.size() != 0) $display("FAIL %s reads missing: got %0d left want 0", tag, exp_a.size()); else passed++;
      total++;
      if (done_cyc != ((cnt == 0) ? 1 : last_hs + 1)) $display("FAIL %s done timing: got %0d want %0d", tag, done_cyc, (cnt == 0) ? 1 : last_hs + 1);
      else passed++;
      @(negedge clock);
      w_ready = 1'b0;
      total++; if ({s_busy, s_done, s_valid} !== 3'b000) $display("FAIL %s idle after done: got %b want 000", tag, {s_busy, s_done, s_valid}); else passed++;
      $display("run %s base=%0d count=%0d first_valid=%0d last_hs=%0d done=%0d reads=%0d", tag, base, cnt, first_valid, last_hs, done_cyc, nreads);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      total++; if ({ctrl8, addr8, wd8, wv8, wl8, busy8, done8} !== '0) $display("FAIL reset8: got %h want 0", {ctrl8, addr8, wd8, wv8, wl8, busy8, done8}); else passed++;
      total++; if ({ctrl5, addr5, wd5, wv5, wl5, busy5, done5} !== '0) $display("FAIL reset5: got %h want 0", {ctrl5, addr5, wd5, wv5, wl5, busy5, done5}); else passed++;
      reset = 1'b1;
      @(negedge clock);
      total++; if ({busy8, done8, wv8, ctrl8} !== '0) $display("FAIL reset idle: got %b want 0", {busy8, done8, wv8, ctrl8}); else passed++;
   endtask

   task automatic test_prec5();
      mem[0] = 24'h007FFF;
      run_stream(12'd0, 13'd1, 0, 1'b1, 1'b0, 1'b0, "prec5");
      total++; if ({first_valid, last_hs, done_cyc} !== {32'd3, 32'd5, 32'd6}) $display("FAIL prec5 timing: got %0d/%0d/%0d want 3/5/6", first_valid, last_hs, done_cyc); else passed++;
      total++; if (got_w.size() != 3 || got_w[0] !== 16'hFFFF || got_w[2] !== 16'hFFFF) $display("FAIL prec5 values: got %0d items want 3 x ffff", got_w.size()); else passed++;
   endtask

   task automatic test_prec8();
      mem[10] = 24'h7F8001;
      run_stream(12'd10, 13'd1, 0, 1'b0, 1'b0, 1'b0, "prec8");
      total++; if ({first_valid, last_hs, done_cyc} !== {32'd3, 32'd5, 32'd6}) $display("FAIL prec8 timing: got %0d/%0d/%0d want 3/5/6", first_valid, last_hs, done_cyc); else passed++;
      total++;
      if (got_w.size() != 3 || got_w[0] !== 16'h0001 || got_w[1] !== 16'hFF80 || got_w[2] !== 16'h007F)
         $display("FAIL prec8 values: got %0d items want 0001 ff80 007f", got_w.size());
      else passed++;
   endtask

   task automatic test_stall();
      run_stream(12'd20, 13'd3, 1, 1'b0, 1'b0, 1'b0, "stall");
      total++; if (nreads != 3) $display("FAIL stall reads: got %0d want 3", nreads); else passed++;
      total++; if (got_w.size() != 9) $display("FAIL stall weights: got %0d want 9", got_w.size()); else passed++;
   endtask

   task automatic test_zero();
      run_stream(12'd5, 13'd0, 0, 1'b0, 1'b0, 1'b0, "zero");
      total++; if (nreads != 0 || got_w.size() != 0) $display("FAIL zero activity: got %0d reads %0d weights want 0 0", nreads, got_w.size()); else passed++;
   endtask

   task automatic test_wrap_busy();
      run_stream(12'd4095, 13'd2, 0, 1'b0, 1'b1, 1'b0, "wrap");
      total++; if (last_hs != 10) $display("FAIL wrap row rate: got last handshake %0d want 10", last_hs); else passed++;
   endtask

   task automatic test_back_to_back();
      run_stream(12'd40, 13'd2, 0, 1'b0, 1'b0, 1'b0, "b2b_a");
      run_stream(12'd60, 13'd2, 0, 1'b0, 1'b0, 1'b1, "b2b_b");
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++)
         run_stream(12'($urandom), 13'($urandom_range(0, 5)), 2, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "random");
   endtask

   task automatic test_reset_midrun();
      @(negedge clock);
      use5 = 1'b0; base_addr = 12'd200; row_count = 13'd3; start = 1'b1; w_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         if (k == 1) start = 1'b0;
      end
      total++; if (wv8 !== 1'b1) $display("FAIL midrun precondition: got valid %b want 1", wv8); else passed++;
      reset = 1'b0;
      #1;
      total++; if ({ctrl8, addr8, wd8, wv8, wl8, busy8, done8} !== '0) $display("FAIL midrun async reset: got %h want 0", {ctrl8, addr8, wd8, wv8, wl8, busy8, done8}); else passed++;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         total++; if ({busy8, done8, wv8, ctrl8} !== '0) $display("FAIL post-reset idle cycle %0d: got %b want 0", k, {busy8, done8, wv8, ctrl8}); else passed++;
      end
      w_ready = 1'b0;
      run_stream(12'd300, 13'd2, 2, 1'b0, 1'b0, 1'b0, "after_reset");
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 24'($urandom);
      test_reset();
      test_prec5();
      test_prec8();
      test_stall();
      test_zero();
      test_wrap_busy();
      test_back_to_back();
      test_random();
      test_reset_midrun();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
